dice_game_ctrl: RTL and testbench

Two-player dice game controller that drives the `roll`/`finish` side of the game's dice generators and consumes their `dice` outputs. Each button press runs one round:
- hold `roll` high for a fixed animation window;
- let both dice settle;
- sample both values and award a point to the higher die.

After `ROUNDS` rounds it declares a winner and holds `finish` high, which parks both generators at 9, until a new game is started.

---
 rtl/dice_game_ctrl_if.sv | 26 ++
 rtl/dice_game_ctrl.sv | 113 +++++++++++
 tb/tb_dice_game_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dice_game_ctrl_if.sv
// Dice game controller bundle: button and dice values in,
// roll/finish drive plus score and status out.
interface dice_game_ctrl_if;
   logic       btn;
   logic [3:0] dice_a;
   logic [3:0] dice_b;
   logic       roll;
   logic       finish;
   logic [3:0] score_a;
   logic [3:0] score_b;
   logic [3:0] round_cnt;
   logic [1:0] winner;
   logic       busy;

   modport master (
      input  btn, dice_a, dice_b,
      output roll, finish, score_a, score_b,
      output round_cnt, winner, busy
   );

   modport slave (
      output btn, dice_a, dice_b,
      input  roll, finish, score_a, score_b,
      input  round_cnt, winner, busy
   );
endinterface

// File: rtl/dice_game_ctrl.sv
// Two-player dice game controller: per press, roll, settle,
// judge the higher die; declare a winner after ROUNDS rounds.
module dice_game_ctrl #(
   parameter int unsigned ROLL_CYCLES   = 50,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ROUNDS        = 5
) (
   input  logic             clk,
   input  logic             rst,
   dice_game_ctrl_if.master bus
);
   localparam logic [7:0] ROLL_LD = 8'(ROLL_CYCLES);
   localparam logic [7:0] SET_LD  = 8'(SETTLE_CYCLES);
   localparam logic [3:0] LAST    = 4'(ROUNDS);

   typedef enum logic [2:0] {
      IDLE, ROLL, SETTLE, JUDGE, DONE
   } state_t;

   state_t     state;
   logic [7:0] cnt;

   logic [3:0] da;
   logic [3:0] db;
   logic [3:0] nxt_a;
   logic [3:0] nxt_b;
   logic [3:0] nxt_rc;
   logic [1:0] nxt_win;

   // Out-of-range die values lose every comparison except a tie.
   function automatic logic [3:0] clamp(input logic [3:0] v);
      return (v == 4'd0 || v > 4'd9) ? 4'd0 : v;
   endfunction

   always_comb begin
      da      = clamp(bus.dice_a);
      db      = clamp(bus.dice_b);
      nxt_a   = bus.score_a;
      nxt_b   = bus.score_b;
      nxt_rc  = bus.round_cnt + 4'd1;
      nxt_win = 2'b11;
      if (da > db) nxt_a = bus.score_a + 4'd1;
      if (db > da) nxt_b = bus.score_b + 4'd1;
      if (nxt_a > nxt_b) nxt_win = 2'b01;
      if (nxt_b > nxt_a) nxt_win = 2'b10;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         bus.roll      <= 1'b0;
         bus.finish    <= 1'b0;
         bus.score_a   <= '0;
         bus.score_b   <= '0;
         bus.round_cnt <= '0;
         bus.winner    <= '0;
         bus.busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.btn) begin
                  state    <= ROLL;
                  cnt      <= ROLL_LD;
                  bus.roll <= 1'b1;
                  bus.busy <= 1'b1;
               end
            end
            ROLL: begin
               if (cnt == 8'd1) begin
                  state    <= SETTLE;
                  cnt      <= SET_LD;
                  bus.roll <= 1'b0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            SETTLE: begin
               if (cnt == 8'd1) state <= JUDGE;
               else             cnt   <= cnt - 8'd1;
            end
            JUDGE: begin
               bus.score_a   <= nxt_a;
               bus.score_b   <= nxt_b;
               bus.round_cnt <= nxt_rc;
               bus.busy      <= 1'b0;
               if (nxt_rc == LAST) begin
                  state      <= DONE;
                  bus.finish <= 1'b1;
                  bus.winner <= nxt_win;
               end else begin
                  state <= IDLE;
               end
            end
            DONE: begin
               // A press here restarts the game and rolls at once.
               if (bus.btn) begin
                  state         <= ROLL;
                  cnt           <= ROLL_LD;
                  bus.roll      <= 1'b1;
                  bus.busy      <= 1'b1;
                  bus.finish    <= 1'b0;
                  bus.score_a   <= '0;
                  bus.score_b   <= '0;
                  bus.round_cnt <= '0;
                  bus.winner    <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dice_game_ctrl.sv
// Scoreboard bench for dice_game_ctrl: a game-level model queues
// round results, a monitor checks them as each round ends.
module tb_dice_game_ctrl;
   localparam int R = 50;
   localparam int S = 2;
   localparam int N = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dice_game_ctrl_if bus();

   dice_game_ctrl #(
      .ROLL_CYCLES  (R),
      .SETTLE_CYCLES(S),
      .ROUNDS       (N)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   int compared   = 0;
   int mismatched = 0;
   int rounds_seen = 0;

   logic [14:0] sbq[$];

   int sa = 0;
   int sb = 0;
   int rc = 0;
   bit over = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int value_of(input logic [3:0] v);
      int x = int'(v);
      return (x >= 1 && x <= 9) ? x : 0;
   endfunction

   function automatic logic [14:0] pack(input int a, input int b,
                                        input int r, input bit f,
                                        input logic [1:0] w);
      return {4'(a), 4'(b), 4'(r), f, w};
   endfunction

   function automatic logic [14:0] observed();
      return {bus.score_a, bus.score_b, bus.round_cnt,
              bus.finish, bus.winner};
   endfunction

   function automatic logic [1:0] verdict();
      if (!over)   return 2'b00;
      if (sa > sb) return 2'b01;
      if (sb > sa) return 2'b10;
      return 2'b11;
   endfunction

   // Monitor: checks window lengths and pops one result per round.
   initial begin : monitor
      bit pr = 0;
      bit pb = 0;
      int nr = 0;
      int nb = 0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.roll) nr++;
         if (bus.busy) nb++;
         if (rst) begin
            nr = 0;
            nb = 0;
         end else begin
            if (pr && !bus.roll) begin
               chk("roll_len", 32'(nr), 32'(R));
               nr = 0;
            end
            if (pb && !bus.busy) begin
               chk("busy_len", 32'(nb), 32'(R + S + 1));
               nb = 0;
               if (sbq.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("FAIL unexpected_round: got 0x%0h expected none",
                           observed());
               end else begin
                  chk("round_result", 32'(observed()),
                      32'(sbq.pop_front()));
               end
               rounds_seen++;
            end
         end
         pr = bus.roll;
         pb = bus.busy;
      end
   end

   task automatic wait_round(input int target, input bit noisy);
      for (int i = 0; i < 4 * (R + S + 4); i++) begin
         @(negedge clk);
         if (rounds_seen >= target) begin
            bus.btn = 1'b0;
            return;
         end
         bus.btn = (noisy && bus.busy && $urandom_range(0, 4) == 0);
      end
      bus.btn = 1'b0;
      compared++;
      mismatched++;
      $display("FAIL round_timeout: got %0d rounds expected %0d",
               rounds_seen, target);
   endtask

   task automatic press(input logic [3:0] a, input logic [3:0] b,
                        input bit noisy);
      int target;
      bit restart;
      int va;
      int vb;
      restart = over;
      if (over) begin
         sa = 0;
         sb = 0;
         rc = 0;
         over = 0;
      end
      va = value_of(a);
      vb = value_of(b);
      if (va > vb) sa++;
      if (vb > va) sb++;
      rc++;
      over = (rc == N);
      sbq.push_back(pack(sa, sb, rc, over, verdict()));
      bus.dice_a = a;
      bus.dice_b = b;
      bus.btn = 1'b1;
      target = rounds_seen + 1;
      @(negedge clk);
      bus.btn = 1'b0;
      if (restart)
         chk("restart", 32'({observed(), bus.roll}), 32'(16'h0001));
      wait_round(target, noisy);
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic hold_check(input int cycles);
      logic [14:0] exp;
      int drops = 0;
      exp = pack(sa, sb, rc, over, verdict());
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (observed() !== exp) drops++;
      end
      chk("hold_changes", 32'(drops), 32'd0);
      chk("hold_state", 32'(observed()), 32'(exp));
   endtask

   initial begin : driver
      rst = 1'b1;
      bus.btn = 1'b0;
      bus.dice_a = 4'd0;
      bus.dice_b = 4'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_outputs", 32'({observed(), bus.roll, bus.busy}), 32'd0);

      // A wins 3 (7-3, 9-2, 8-4), B wins 1 (0-1), one tie (5-5).
      press(4'd7, 4'd3, 1'b1);
      chk("round1_finish", 32'(bus.finish), 32'd0);
      press(4'd5, 4'd5, 1'b1);
      press(4'd0, 4'd1, 1'b0);
      press(4'd9, 4'd2, 1'b0);
      press(4'd8, 4'd4, 1'b1);
      chk("game1_final", 32'(observed()), 32'(pack(3, 1, 5, 1'b1, 2'b01)));
      hold_check(100);

      // Draw game: one win each, and two ties counting invalid values.
      press(4'd2, 4'd6, 1'b0);
      press(4'd6, 4'd2, 1'b0);
      press(4'd4, 4'd4, 1'b0);
      press(4'd15, 4'd0, 1'b1);
      press(4'd12, 4'd10, 1'b0);
      chk("draw_winner", 32'(bus.winner), 32'd3);
      hold_check(10);

      for (int i = 0; i < 8; i++)
         press(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)));

      // Reset after 20 cycles of roll.
      bus.btn = 1'b1;
      @(negedge clk);
      bus.btn = 1'b0;
      repeat (19) @(negedge clk);
      chk("roll_before_rst", 32'(bus.roll), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_roll_reset", 32'({observed(), bus.roll, bus.busy}), 32'd0);
      sa = 0;
      sb = 0;
      rc = 0;
      over = 0;

      rst = 1'b1;
      bus.btn = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.btn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_btn_idle", 32'({bus.roll, bus.busy}), 32'd0);

      for (int i = 0; i < 7; i++)
         press(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)));

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end
endmodule
